// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time through a REQ/WAIT/HOLD
// handshake, with control-flow redirects and discarding of in-flight responses.
module ysyx_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] inst, inst_n;
    logic        drop, drop_n;
    // Low for the cycle after reset so no request is issued while rst is high.
    logic        run;
    logic        req_hs;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    assign imem_req_valid = run && (state == REQ);
    assign imem_addr      = pc;
    assign out_valid      = (state == HOLD);
    assign out_inst       = inst;
    assign out_pc         = pc;

    assign req_hs = imem_req_valid && imem_req_ready;

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst;
        drop_n  = drop;
        case (state)
            REQ: begin
                if (req_hs) begin
                    state_n = WAIT;
                    if (redirect_valid) drop_n = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    drop_n = 1'b0;
                    if (drop || redirect_valid) begin
                        state_n = REQ;
                    end else begin
                        state_n = HOLD;
                        inst_n  = imem_rdata;
                    end
                end else if (redirect_valid) begin
                    drop_n = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) pc_n = pc + 32'd4;
                if (out_ready || redirect_valid) state_n = REQ;
            end
            default: state_n = REQ;
        endcase
        // A redirect always wins over the sequential increment.
        if (redirect_valid) pc_n = {redirect_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc    <= RESET_PC;
            inst  <= NOP;
            drop  <= 1'b0;
            run   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            inst  <= inst_n;
            drop  <= drop_n;
            run   <= 1'b1;
        end
    end
endmodule
